// File: rtl/mcp3x0x_pkg.sv
// Shared types, frame constants and channel-selection helper for the
// MCP3x0x scanning SPI master.
package mcp3x0x_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic START_BIT  = 1'b1;
  localparam int   N_CMD_BITS = 5;   // start, SGL/DIFF, D2..D0
  localparam int   N_PRE_DATA = 7;   // command bits + sample period + null bit

  // Next set bit of mask strictly after cur, wrapping 7->0; cur itself is
  // checked last so a single-bit mask repeats the same channel.
  function automatic logic [2:0] next_channel(input logic [7:0] mask,
                                              input logic [2:0] cur);
    logic [2:0] idx;
    logic       found;
    next_channel = cur;
    found        = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = cur + 3'(i);
      if (!found && mask[idx]) begin
        next_channel = idx;
        found        = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

endpackage

// File: rtl/mcp3x0x_scan_ctrl_if.sv
// Result stream from the scan controller: data + channel with valid/ready.
interface mcp3x0x_scan_ctrl_if #(
  parameter int RES_BITS = 10
);
  logic [RES_BITS-1:0] sample_data;
  logic [2:0]          sample_ch;
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output sample_data, sample_ch, sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data, sample_ch, sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/mcp3x0x_scan_ctrl_sclk_gen.sv
// SCLK generator: CLK_DIV clk cycles per half period while run_i is high,
// held low and restarted from the start of a low phase when run_i drops.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic sclk_o,
  output logic rise_stb_o,     // sclk goes high at the coming clk edge
  output logic fall_stb_o,     // sclk goes low at the coming clk edge
  output logic period_done_o   // last cycle of the high phase
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap_s;

  assign wrap_s        = (cnt_q == CW'(CLK_DIV - 1));
  assign rise_stb_o    = run_i & wrap_s & ~sclk_q;
  assign fall_stb_o    = run_i & wrap_s & sclk_q;
  assign period_done_o = fall_stb_o;
  assign sclk_o        = sclk_q;

  // Half-period counter and sclk toggle.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!run_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (wrap_s) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      sclk_d = sclk_q;
    end
  end

  // Counter and sclk registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
endmodule

// File: rtl/mcp3x0x_scan_ctrl.sv
// Round-robin scanning SPI master for MCP3004/3008/3204/3208 ADCs.
// One frame per masked channel; results leave on a valid/ready stream
// with sticky overrun detection.
module mcp3x0x_scan_ctrl
  import mcp3x0x_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int RES_BITS = 10,
  parameter int SGL      = 1,
  parameter int CS_IDLE  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic [7:0]          ch_mask_i,
  output logic                sclk_o,
  output logic                cs_n_o,
  output logic                mosi_o,
  input  logic                miso_i,
  output logic                overrun_o,
  input  logic                clr_overrun_i,
  mcp3x0x_scan_ctrl_if.master smp
);
  localparam int   FRAME   = N_PRE_DATA + RES_BITS;
  localparam int   GAP_CYC = CS_IDLE * 2 * CLK_DIV;
  localparam int   TW      = $clog2(GAP_CYC + 1);
  localparam logic SGL_BIT = (SGL != 0) ? 1'b1 : 1'b0;

  // Command bit driven during SCLK period k.
  function automatic logic cmd_bit(input logic [4:0] k, input logic [2:0] ch);
    logic b;
    if (k >= 5'(N_CMD_BITS)) begin
      b = 1'b0;
    end else begin
      case (k[2:0])
        3'd0:    b = START_BIT;
        3'd1:    b = SGL_BIT;
        3'd2:    b = ch[2];
        3'd3:    b = ch[1];
        3'd4:    b = ch[0];
        default: b = 1'b0;
      endcase
    end
    return b;
  endfunction

  state_t              state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [4:0]          k_q, k_d;
  logic [2:0]          ch_q, ch_d;
  logic                cs_n_q, cs_n_d;
  logic                mosi_q, mosi_d;
  logic [RES_BITS-1:0] shift_q, shift_d;
  logic                load_q, load_d;
  logic [RES_BITS-1:0] data_q, data_d;
  logic [2:0]          sch_q, sch_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic                run_s, sclk_s, rise_s, fall_s, pdone_s;

  assign run_s = (state_q == SHIFT);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_i        (run_s),
    .sclk_o       (sclk_s),
    .rise_stb_o   (rise_s),
    .fall_stb_o   (fall_s),
    .period_done_o(pdone_s)
  );

  assign sclk_o           = sclk_s;
  assign cs_n_o           = cs_n_q;
  assign mosi_o           = mosi_q;
  assign overrun_o        = ovr_q;
  assign smp.sample_data  = data_q;
  assign smp.sample_ch    = sch_q;
  assign smp.sample_valid = valid_q;

  // Frame sequencing, shifting and result handshake.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    k_d     = k_q;
    ch_d    = ch_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    shift_d = shift_q;
    load_d  = 1'b0;
    data_d  = data_q;
    sch_d   = sch_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    case (state_q)
      IDLE: begin
        if (enable_i && (ch_mask_i != 8'h00)) begin
          state_d = SETUP;
          ch_d    = next_channel(ch_mask_i, ch_q);
          cs_n_d  = 1'b0;
          tmr_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (tmr_q == TW'(CLK_DIV - 1)) begin
          state_d = SHIFT;
          k_d     = 5'd0;
          mosi_d  = cmd_bit(5'd0, ch_q);
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      SHIFT: begin
        // Sample and null-bit periods carry no data.
        if (rise_s && (k_q >= 5'(N_PRE_DATA))) begin
          shift_d = {shift_q[RES_BITS-2:0], miso_i};
        end else begin
          shift_d = shift_q;
        end
        if (fall_s) begin
          mosi_d = (k_q == 5'(FRAME - 1)) ? 1'b0 : cmd_bit(k_q + 5'd1, ch_q);
        end else begin
          mosi_d = mosi_q;
        end
        if (pdone_s) begin
          if (k_q == 5'(FRAME - 1)) begin
            state_d = GAP;
            cs_n_d  = 1'b1;
            load_d  = 1'b1;
            tmr_d   = '0;
          end else begin
            k_d = k_q + 5'd1;
          end
        end else begin
          k_d = k_q;
        end
      end
      GAP: begin
        if (tmr_q == TW'(GAP_CYC - 1)) begin
          if (enable_i && (ch_mask_i != 8'h00)) begin
            state_d = SETUP;
            ch_d    = next_channel(ch_mask_i, ch_q);
            cs_n_d  = 1'b0;
            tmr_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
      end
    endcase

    // A fresh result overwrites an unaccepted one and flags it.
    if (load_q) begin
      data_d  = shift_q;
      sch_d   = ch_q;
      valid_d = 1'b1;
    end else if (valid_q && smp.sample_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (clr_overrun_i) begin
      ovr_d = 1'b0;
    end else if (load_q && valid_q && !smp.sample_ready) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State and output registers; the pointer resets to 7 so the first scan
  // starts at the lowest masked channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      k_q     <= 5'd0;
      ch_q    <= 3'd7;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      shift_q <= '0;
      load_q  <= 1'b0;
      data_q  <= '0;
      sch_q   <= 3'd0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      k_q     <= k_d;
      ch_q    <= ch_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      shift_q <= shift_d;
      load_q  <= load_d;
      data_q  <= data_d;
      sch_q   <= sch_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
endmodule

// File: tb/tb_mcp3x0x_scan_ctrl.sv
// Directed bench: default 10-bit instance plus a 12-bit pseudo-differential
// instance, each talking to a small behavioural ADC model.
module tb_mcp3x0x_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, clr;
  logic [7:0] ch_mask;
  logic       sclk, cs_n, mosi, miso;
  logic       overrun;
  logic       en12;
  logic       sclk12, cs_n12, mosi12, miso12, overrun12;

  int n_chk  = 0;
  int n_pass = 0;
  int mode   = 0;

  mcp3x0x_scan_ctrl_if #(.RES_BITS(10)) smp_if ();
  mcp3x0x_scan_ctrl_if #(.RES_BITS(12)) smp12_if ();

  mcp3x0x_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .ch_mask_i(ch_mask),
    .sclk_o(sclk), .cs_n_o(cs_n), .mosi_o(mosi), .miso_i(miso),
    .overrun_o(overrun), .clr_overrun_i(clr), .smp(smp_if.master)
  );

  mcp3x0x_scan_ctrl #(.CLK_DIV(1), .RES_BITS(12), .SGL(0), .CS_IDLE(1)) dut12 (
    .clk(clk), .rst_n(rst_n), .enable_i(en12), .ch_mask_i(8'h08),
    .sclk_o(sclk12), .cs_n_o(cs_n12), .mosi_o(mosi12), .miso_i(miso12),
    .overrun_o(overrun12), .clr_overrun_i(1'b0), .smp(smp12_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- 10-bit ADC model ----------------
  int         rk, fk;
  logic [4:0] cmd, cmd_last;
  logic [9:0] mv;

  function automatic logic [9:0] adc_val(input logic [2:0] ch);
    int t;
    t = 10 * int'(ch);
    if (mode == 0) return 10'h2A5;
    else return t[9:0];
  endfunction

  always @(negedge cs_n) begin rk = 0; fk = 0; cmd = 5'd0; miso = 1'b0; end
  always @(posedge sclk) if (cs_n === 1'b0) begin
    if (rk < 5) cmd = {cmd[3:0], mosi};
    rk++;
    if (rk == 5) cmd_last = cmd;
  end
  always @(negedge sclk) if (cs_n === 1'b0) begin
    fk++;
    if (fk >= 7 && fk <= 16) begin mv = adc_val(cmd[2:0]); miso = mv[16-fk]; end
    else miso = 1'b0;
  end

  // ---------------- 12-bit ADC model ----------------
  int          rk12, fk12, rk12_last;
  logic [4:0]  cmd12, cmd12_last;
  logic [11:0] mv12;

  always @(negedge cs_n12) begin rk12 = 0; fk12 = 0; cmd12 = 5'd0; miso12 = 1'b0; end
  always @(posedge cs_n12) rk12_last = rk12;
  always @(posedge sclk12) if (cs_n12 === 1'b0) begin
    if (rk12 < 5) cmd12 = {cmd12[3:0], mosi12};
    rk12++;
    if (rk12 == 5) cmd12_last = cmd12;
  end
  always @(negedge sclk12) if (cs_n12 === 1'b0) begin
    fk12++;
    mv12 = 12'hABC;
    if (fk12 >= 7 && fk12 <= 18) miso12 = mv12[18-fk12];
    else miso12 = 1'b0;
  end

  // ---------------- helpers ----------------
  int          lo, hi, vat;
  logic [11:0] cap_data;
  logic [2:0]  cap_ch;

  task automatic wait_cs_fall();
    int c = 0;
    while (cs_n !== 1'b0 && c < 2000) begin @(negedge clk); c++; end
    check("cs_fall_timeout", 32'(c < 2000), 32'd1);
  endtask

  // Measures one frame from cs_n fall: low length, following high length,
  // and the cycle index of the first sample_valid.
  task automatic measure_frame();
    int t = 0;
    vat = -1; cap_data = '1; cap_ch = 3'd0;
    wait_cs_fall();
    while (cs_n === 1'b0 && t < 1000) begin
      if (smp_if.sample_valid && vat < 0) begin vat = t; cap_data = 12'(smp_if.sample_data); cap_ch = smp_if.sample_ch; end
      @(negedge clk); t++;
    end
    lo = t;
    while (cs_n === 1'b1 && t < 2000) begin
      if (smp_if.sample_valid && vat < 0) begin vat = t; cap_data = 12'(smp_if.sample_data); cap_ch = smp_if.sample_ch; end
      @(negedge clk); t++;
    end
    hi = t - lo;
  endtask

  int exp_ch [4] = '{2, 5, 7, 2};

  initial begin
    int c;
    rst_n = 1'b0; enable = 1'b0; ch_mask = 8'h00; clr = 1'b0; en12 = 1'b0;
    smp_if.sample_ready = 1'b1; smp12_if.sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_valid", 32'(smp_if.sample_valid), 32'd0);
    check("rst_data", 32'(smp_if.sample_data), 32'd0);
    check("rst_ch", 32'(smp_if.sample_ch), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Single channel 0, constant 0x2A5
    rst_n = 1'b1; @(negedge clk);
    ch_mask = 8'h01; enable = 1'b1;
    measure_frame();
    check("t1_cs_low", 32'(lo), 32'd70);
    check("t1_cs_high", 32'(hi), 32'd16);
    check("t1_latency", 32'(vat), 32'd71);
    check("t1_data", 32'(cap_data), 32'h2A5);
    check("t1_ch", 32'(cap_ch), 32'd0);
    check("t1_cmd", 32'(cmd_last), 32'b11000);

    // Mask change during a ch0 frame does not affect it
    ch_mask = 8'b1010_0100; mode = 1;
    measure_frame();
    check("t2_mid_ch", 32'(cap_ch), 32'd0);
    check("t2_mid_data", 32'(cap_data), 32'd0);
    for (int i = 0; i < 4; i++) begin
      measure_frame();
      check("t2_ch", 32'(cap_ch), 32'(exp_ch[i]));
      check("t2_data", 32'(cap_data), 32'(10 * exp_ch[i]));
      check("t2_cmd", 32'(cmd_last), 32'({2'b11, 3'(exp_ch[i])}));
    end

    // Overrun: two unaccepted results (ch5 then ch7); now at ch5 cs_n fall
    smp_if.sample_ready = 1'b0;
    repeat (72) @(negedge clk);
    check("t3_valid1", 32'(smp_if.sample_valid), 32'd1);
    check("t3_data1", 32'(smp_if.sample_data), 32'd50);
    check("t3_ovr1", 32'(overrun), 32'd0);
    repeat (86) @(negedge clk);
    check("t3_ovr2", 32'(overrun), 32'd1);
    check("t3_data2", 32'(smp_if.sample_data), 32'd70);
    check("t3_ch2", 32'(smp_if.sample_ch), 32'd7);
    check("t3_valid2", 32'(smp_if.sample_valid), 32'd1);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("t3_clr", 32'(overrun), 32'd0);
    smp_if.sample_ready = 1'b1; @(negedge clk);
    check("t3_accept", 32'(smp_if.sample_valid), 32'd0);

    // enable drops at SCLK period 8 of the ch2 frame
    wait_cs_fall();
    repeat (34) @(negedge clk);
    enable = 1'b0;
    c = 0;
    while (!smp_if.sample_valid && c < 200) begin @(negedge clk); c++; end
    check("t4_valid_seen", 32'(c < 200), 32'd1);
    check("t4_data", 32'(smp_if.sample_data), 32'd20);
    check("t4_ch", 32'(smp_if.sample_ch), 32'd2);
    c = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || sclk !== 1'b0) c++;
    end
    check("t4_idle", 32'(c), 32'd0);

    // Reset at SCLK period 10 of the ch5 frame
    enable = 1'b1;
    wait_cs_fall();
    repeat (42) @(negedge clk);
    rst_n = 1'b0; #1;
    check("t5_cs_n", 32'(cs_n), 32'd1);
    check("t5_sclk", 32'(sclk), 32'd0);
    check("t5_valid", 32'(smp_if.sample_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    measure_frame();
    check("t5_restart_ch", 32'(cap_ch), 32'd2);
    check("t5_restart_data", 32'(cap_data), 32'd20);
    check("t5_latency", 32'(vat), 32'd71);
    enable = 1'b0;

    // 12-bit pseudo-differential instance, channel 3
    en12 = 1'b1;
    c = 0;
    while (cs_n12 !== 1'b0 && c < 200) begin @(negedge clk); c++; end
    check("t6_cs_fall", 32'(c < 200), 32'd1);
    c = 0;
    while (!smp12_if.sample_valid && c < 200) begin @(negedge clk); c++; end
    check("t6_latency", 32'(c), 32'd40);
    check("t6_data", 32'(smp12_if.sample_data), 32'hABC);
    check("t6_ch", 32'(smp12_if.sample_ch), 32'd3);
    check("t6_cmd", 32'(cmd12_last), 32'b10011);
    check("t6_sclk_periods", 32'(rk12_last), 32'd19);
    en12 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mcp3x0x_scan_ctrl.md
Name: mcp3x0x_scan_ctrl

Overview:
- Parametrised SPI master for MCP3004/3008 (10-bit) and MCP3204/3208 (12-bit) ADCs.
- Automatically scans a mask-selected set of up to 8 channels, round-robin, one conversion frame per channel.
- Delivers each result with its channel number over a valid/ready interface, with overrun detection.
- Sits between the ADC Pmod pins and downstream consumers (7-seg display, accel mapping), replacing the fixed single-channel sequencer.

Parameters:
- CLK_DIV, 2, clk cycles per SCLK half-period (>=1).
- RES_BITS, 10, ADC resolution; legal values 10 or 12.
- SGL, 1, 1 = single-ended, 0 = pseudo-differential (sent as the SGL/DIFF bit).
- CS_IDLE, 4, minimum SCLK periods cs_n stays high between frames (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = keep scanning; 0 = finish current frame, then idle
- ch_mask  in  8  channels to scan; bit i = channel i
- sclk  out  1  ADC serial clock, idle low
- cs_n  out  1  ADC chip select, active low
- mosi  out  1  ADC DIN
- miso  in  1  ADC DOUT
- sample_data  out  RES_BITS  conversion result, unsigned
- sample_ch  out  3  channel of sample_data
- sample_valid  out  1  result available
- sample_ready  in  1  consumer accepts the result
- overrun  out  1  sticky: a result was overwritten before acceptance
- clr_overrun  in  1  synchronous clear of overrun

Behaviour:
- Reset (async, immediate, also mid-frame):
  - Outputs: cs_n=1, sclk=0, mosi=0, sample_valid=0, sample_data=0, sample_ch=0, overrun=0.
  - State: IDLE; current channel pointer = 7, so the first scan selects the lowest set bit.
- States: IDLE -> SETUP -> SHIFT -> GAP -> (SETUP | IDLE).
- IDLE:
  - Leave when enable=1 and ch_mask!=0.
  - Latch ch_mask; pick the next set bit after the pointer, wrapping 7->0.
  - cs_n falls on entry to SETUP.
- SETUP: CLK_DIV cycles with cs_n=0, sclk=0.
- SHIFT:
  - FRAME = 7+RES_BITS SCLK periods k=0..FRAME-1; each period is CLK_DIV cycles low, then CLK_DIV cycles high.
  - mosi is updated at the start of each low phase: k=0 start bit 1, k=1 SGL, k=2..4 channel[2:0] MSB first, k>=5 0.
  - miso is sampled in the clk cycle sclk rises for k=7..FRAME-1, shifted in MSB first. k=5 (sample) and k=6 (null bit) are ignored.
- End of the last high phase:
  - sclk=0 and cs_n=1 in the same cycle.
  - sample_data/sample_ch load in that cycle; sample_valid=1 from the next cycle.
- Latency: cs_n fall to sample_valid rise = CLK_DIV + FRAME*2*CLK_DIV + 1 cycles (71 at defaults).
- GAP:
  - cs_n=1 for CS_IDLE*2*CLK_DIV cycles.
  - Then SETUP for the next masked channel if enable=1 and the latched mask!=0; otherwise IDLE.
  - ch_mask is re-latched at every channel selection; mid-frame changes do not affect the current frame.
- Handshake:
  - Transfer occurs when sample_valid & sample_ready; sample_valid drops the next cycle unless a new result loads in that same cycle.
  - New result while sample_valid=1 and not accepted that cycle: overwrite data/ch, keep valid=1, set overrun.
  - Acceptance and a new load in the same cycle: valid stays 1, no overrun.
- overrun: clr_overrun wins over a simultaneous set.
- enable deassert mid-frame: the frame completes and its result is delivered; then IDLE.
- Single-bit mask: the same channel repeats every frame.

Decomposition:
- Package mcp3x0x_pkg:
  - state_t enum {IDLE, SETUP, SHIFT, GAP}
  - START_BIT=1, N_CMD_BITS=5, N_PRE_DATA=7
  - function next_channel(mask, cur) returning the next set bit with wrap.
- Sub-module spi_sclk_gen: CLK_DIV half-period counter with run input; outputs sclk, rise_stb, fall_stb, period_done.

Test Plan:
- Defaults, ch_mask=8'h01, enable=1, model returns 10'h2A5 -> mosi bits 1,1,0,0,0; first sample_valid 71 cycles after cs_n fall; sample_data=10'h2A5, sample_ch=0; cs_n high 16 cycles between frames.
- ch_mask=8'b1010_0100, model returns 10*ch -> sample_ch sequence 2,5,7,2,... with data 20,50,70,20.
- RES_BITS=12, SGL=0, ch_mask=8'h08, model returns 12'hABC -> mosi 1,0,0,1,1; 19 SCLK periods; sample_data=12'hABC.
- sample_ready=0 for two frames -> overrun=1 after the second result, sample_data holds the second value; clr_overrun=1 -> overrun=0.
- enable=0 at SCLK period 8 -> frame completes, result delivered, then cs_n stays 1 and sclk 0.
- rst_n low at period 10 -> cs_n=1, sclk=0, sample_valid=0 in the same cycle; after release, the scan restarts from the lowest masked channel.
